// File: rtl/dcache_port_arbiter.sv
// Single data-cache port shared by committed stores (buffered) and speculative loads.
// One cache transaction in flight; stores drain from a circular buffer, loads may be squashed.
//
// state  | meaning
// S_IDLE | pick store/load, latch request register
// S_REQ  | mem_req_valid held until mem_req_ready
// S_WAIT | waiting on mem_resp_valid; pop store or return load data
module dcache_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SB_DEPTH   = 4,
   parameter int LQ_ID_W    = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               commit_store_valid,
   input  logic [ADDR_W-1:0]  commit_store_addr,
   input  logic [DATA_W-1:0]  commit_store_data,
   output logic               sb_full,
   output logic               sb_empty,
   input  logic               ld_req_valid,
   input  logic [ADDR_W-1:0]  ld_req_addr,
   input  logic [LQ_ID_W-1:0] ld_req_id,
   output logic               ld_req_ready,
   output logic               ld_resp_valid,
   output logic [DATA_W-1:0]  ld_resp_data,
   output logic [LQ_ID_W-1:0] ld_resp_id,
   input  logic               flush,
   output logic               mem_req_valid,
   output logic               mem_req_we,
   output logic [ADDR_W-1:0]  mem_req_addr,
   output logic [DATA_W-1:0]  mem_req_wdata,
   input  logic               mem_req_ready,
   input  logic               mem_resp_valid,
   input  logic [DATA_W-1:0]  mem_resp_rdata
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0]  sb_addr [SB_DEPTH];
   logic [DATA_W-1:0]  sb_data [SB_DEPTH];
   logic [SB_DEPTH-1:0] sb_vld;
   logic [PTR_W:0]     head, tail;
   logic [PTR_W-1:0]   head_idx, tail_idx;

   logic [ADDR_W-1:0]  req_addr;
   logic [DATA_W-1:0]  req_wdata;
   logic               req_we;
   logic [LQ_ID_W-1:0] req_id;
   logic               kill;
   logic [CNT_W-1:0]   starve;

   logic addr_hit, load_ok, store_sel, load_sel;
   logic store_grant, load_grant, sb_pop, sb_push;

   assign head_idx = head[PTR_W-1:0];
   assign tail_idx = tail[PTR_W-1:0];
   assign sb_empty = (head == tail);
   assign sb_full  = (head[PTR_W] != tail[PTR_W]) && (head_idx == tail_idx);

   // Word-granular match: a load overlapping any buffered store must wait for it to drain.
   always_comb begin
      addr_hit = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_vld[i] && (sb_addr[i][ADDR_W-1:2] == ld_req_addr[ADDR_W-1:2]))
            addr_hit = 1'b1;
      end
   end

   assign load_ok   = ld_req_valid && !flush;
   assign store_sel = !sb_empty && (sb_full || (starve == CNT_W'(STARVE_MAX)) ||
                                    (ld_req_valid && addr_hit) || !load_ok);
   assign load_sel  = load_ok && !store_sel;

   always_comb begin
      state_nxt   = state;
      store_grant = 1'b0;
      load_grant  = 1'b0;
      sb_pop      = 1'b0;
      case (state)
         S_IDLE: begin
            if (store_sel) begin
               store_grant = 1'b1;
               state_nxt   = S_REQ;
            end else if (load_sel) begin
               load_grant = 1'b1;
               state_nxt  = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_req_ready)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               state_nxt = S_IDLE;
               sb_pop    = req_we;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // A full buffer still takes a push when the head retires in the same cycle.
   assign sb_push = commit_store_valid && (!sb_full || sb_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         head      <= '0;
         tail      <= '0;
         sb_vld    <= '0;
         starve    <= '0;
         kill      <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_we    <= 1'b0;
         req_id    <= '0;
      end else begin
         state <= state_nxt;
         if (sb_pop) begin
            sb_vld[head_idx] <= 1'b0;
            head             <= head + 1'b1;
         end
         if (sb_push) begin
            sb_vld[tail_idx] <= 1'b1;
            tail             <= tail + 1'b1;
         end
         if (store_grant) begin
            req_addr  <= sb_addr[head_idx];
            req_wdata <= sb_data[head_idx];
            req_we    <= 1'b1;
            req_id    <= '0;
         end else if (load_grant) begin
            req_addr  <= ld_req_addr;
            req_wdata <= '0;
            req_we    <= 1'b0;
            req_id    <= ld_req_id;
         end
         if (store_grant || sb_empty)
            starve <= '0;
         else if (load_grant && (starve != CNT_W'(STARVE_MAX)))
            starve <= starve + 1'b1;
         if (state_nxt == S_IDLE)
            kill <= 1'b0;
         else if (flush && !req_we && ((state == S_REQ) || (state == S_WAIT)))
            kill <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (sb_push) begin
         sb_addr[tail_idx] <= commit_store_addr;
         sb_data[tail_idx] <= commit_store_data;
      end
   end

   always @(posedge clk) begin
      if (rst_n)
         assert (!(commit_store_valid && sb_full && !sb_pop))
            else $warning("store buffer overflow, committed store dropped");
   end

   assign ld_req_ready  = rst_n && (state == S_IDLE) && load_sel;
   assign mem_req_valid = rst_n && (state == S_REQ);
   assign mem_req_we    = req_we;
   assign mem_req_addr  = req_addr;
   assign mem_req_wdata = req_wdata;
   // A flush coinciding with the response squashes it as well as a registered kill.
   assign ld_resp_valid = rst_n && (state == S_WAIT) && mem_resp_valid && !req_we && !kill && !flush;
   assign ld_resp_data  = mem_resp_rdata;
   assign ld_resp_id    = req_id;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a memory responder plus a scoreboard monitor
// that checks every cache handshake and load response against queued expectations.
module tb_dcache_port_arbiter;

   localparam logic [31:0] RD_KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit_store_valid;
   logic [31:0] commit_store_addr;
   logic [31:0] commit_store_data;
   logic        sb_full, sb_empty;
   logic        ld_req_valid;
   logic [31:0] ld_req_addr;
   logic [2:0]  ld_req_id;
   logic        ld_req_ready;
   logic        ld_resp_valid;
   logic [31:0] ld_resp_data;
   logic [2:0]  ld_resp_id;
   logic        flush;
   logic        mem_req_valid, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic        mem_req_ready  = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_rdata = '0;

   typedef struct packed {logic [31:0] addr; logic [31:0] data;} st_exp_t;
   typedef struct packed {logic [2:0] id; logic [31:0] data;} ld_exp_t;

   st_exp_t     exp_st[$];
   logic [31:0] exp_lm[$];
   ld_exp_t     exp_ld[$];

   int n_checks = 0;
   int n_err    = 0;

   bit          auto_ready = 1'b1;
   int          resp_lat   = 1;
   int          pend       = 0;
   logic [31:0] pend_data  = '0;

   dcache_port_arbiter dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .commit_store_valid (commit_store_valid),
      .commit_store_addr  (commit_store_addr),
      .commit_store_data  (commit_store_data),
      .sb_full            (sb_full),
      .sb_empty           (sb_empty),
      .ld_req_valid       (ld_req_valid),
      .ld_req_addr        (ld_req_addr),
      .ld_req_id          (ld_req_id),
      .ld_req_ready       (ld_req_ready),
      .ld_resp_valid      (ld_resp_valid),
      .ld_resp_data       (ld_resp_data),
      .ld_resp_id         (ld_resp_id),
      .flush              (flush),
      .mem_req_valid      (mem_req_valid),
      .mem_req_we         (mem_req_we),
      .mem_req_addr       (mem_req_addr),
      .mem_req_wdata      (mem_req_wdata),
      .mem_req_ready      (mem_req_ready),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_rdata     (mem_resp_rdata)
   );

   always #10 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory model: read data is the address XOR a key; latency set by resp_lat.
   always @(negedge clk) begin
      #1;
      mem_resp_valid = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = pend_data;
         end
      end
      mem_req_ready = auto_ready;
      if (mem_req_valid && auto_ready) begin
         pend      = resp_lat;
         pend_data = mem_req_we ? 32'h0 : (mem_req_addr ^ RD_KEY);
      end
   end

   // Scoreboard monitor.
   always @(negedge clk) begin
      #3;
      if (mem_req_valid && mem_req_ready) begin
         if (mem_req_we) begin
            if (exp_st.size() == 0) chk("st_unexpected", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               st_exp_t e;
               e = exp_st.pop_front();
               chk("st_addr", mem_req_addr, e.addr);
               chk("st_wdata", mem_req_wdata, e.data);
            end
         end else begin
            if (exp_lm.size() == 0) chk("ldmem_unexpected", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
               logic [31:0] a;
               a = exp_lm.pop_front();
               chk("ldmem_addr", mem_req_addr, a);
            end
         end
      end
      if (ld_resp_valid) begin
         if (exp_ld.size() == 0) chk("ldresp_unexpected", {29'd0, ld_resp_id}, 64'hFFFF_FFFF_FFFF_FFFF);
         else begin
            ld_exp_t e;
            e = exp_ld.pop_front();
            chk("ldresp_id", ld_resp_id, e.id);
            chk("ldresp_data", ld_resp_data, e.data);
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic issue_load(input logic [31:0] a, input logic [2:0] id, input bit expect_resp);
      int n;
      ld_exp_t e;
      n = 0;
      ld_req_valid = 1'b1;
      ld_req_addr  = a;
      ld_req_id    = id;
      #5;
      while (!ld_req_ready && n < 100) begin
         @(negedge clk); #5;
         n++;
      end
      chk("ld_accept", ld_req_ready, 1);
      if (ld_req_ready) begin
         exp_lm.push_back(a);
         e.id = id;
         e.data = a ^ RD_KEY;
         if (expect_resp) exp_ld.push_back(e);
      end
      @(negedge clk);
      ld_req_valid = 1'b0;
   endtask

   task automatic push_store(input logic [31:0] a, input logic [31:0] d, input bit expect_issue);
      st_exp_t e;
      commit_store_valid = 1'b1;
      commit_store_addr  = a;
      commit_store_data  = d;
      e.addr = a;
      e.data = d;
      if (expect_issue) exp_st.push_back(e);
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (!sb_empty && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, sb_empty, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nst, since, n;
      bit          acc, found, st_seen, got;
      logic [31:0] ld_a;
      logic [2:0]  ld_i;
      ld_exp_t     e;

      rst_n = 1'b0;
      commit_store_valid = 1'b0;
      commit_store_addr  = '0;
      commit_store_data  = '0;
      ld_req_valid = 1'b1;
      ld_req_addr  = 32'h100;
      ld_req_id    = '0;
      flush        = 1'b0;

      // reset state, with a load pending to prove ready is held low
      repeat (2) @(negedge clk);
      #5;
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_ld_req_ready", ld_req_ready, 0);
      chk("rst_ld_resp_valid", ld_resp_valid, 0);
      chk("rst_sb_empty", sb_empty, 1);
      chk("rst_sb_full", sb_full, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ld_req_valid = 1'b0;

      // single load latency: accept N, request N+1, response N+2
      @(negedge clk);
      ld_req_valid = 1'b1;
      ld_req_addr  = 32'h100;
      ld_req_id    = 3'd5;
      exp_lm.push_back(32'h100);
      e.id = 3'd5;
      e.data = 32'h100 ^ RD_KEY;
      exp_ld.push_back(e);
      #5 chk("l0_ready", ld_req_ready, 1);
      @(negedge clk);
      ld_req_valid = 1'b0;
      #5;
      chk("l0_mem_req_valid", mem_req_valid, 1);
      chk("l0_mem_req_we", mem_req_we, 0);
      @(negedge clk);
      #5;
      chk("l0_resp_valid", ld_resp_valid, 1);
      chk("l0_resp_id", ld_resp_id, 5);
      @(negedge clk);

      // fill the buffer behind a stalled load, drop a push, then push during a pop
      auto_ready = 1'b0;
      @(negedge clk);
      issue_load(32'h300, 3'd1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         push_store(32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
         @(negedge clk);
      end
      commit_store_valid = 1'b0;
      #5;
      chk("sb_full_after_4", sb_full, 1);
      chk("sb_empty_after_4", sb_empty, 0);
      @(negedge clk);
      push_store(32'h1010, 32'hBAD0_BAD0, 1'b0);
      @(negedge clk);
      commit_store_valid = 1'b0;
      #5 chk("sb_full_after_drop", sb_full, 1);
      @(negedge clk);
      auto_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk); #5;
         if (mem_resp_valid && mem_req_we) begin
            found = 1'b1;
            push_store(32'h1014, 32'hA000_0005, 1'b1);
         end
      end
      chk("pop_cycle_found", found, 1);
      @(negedge clk);
      commit_store_valid = 1'b0;
      #5 chk("sb_full_push_in_pop", sb_full, 1);
      wait_drain("drain_full_buffer");

      // starvation: two buffered stores under continuous loads
      auto_ready = 1'b0;
      @(negedge clk);
      issue_load(32'h3000, 3'd2, 1'b1);
      push_store(32'h2000, 32'hC0DE_0000, 1'b1);
      @(negedge clk);
      push_store(32'h2004, 32'hC0DE_0001, 1'b1);
      @(negedge clk);
      commit_store_valid = 1'b0;
      auto_ready = 1'b1;
      ld_a = 32'h4000;
      ld_i = 3'd0;
      acc = 1'b0;
      nst = 0;
      since = 0;
      ld_req_valid = 1'b1;
      ld_req_addr  = ld_a;
      ld_req_id    = ld_i;
      for (int k = 0; k < 100 && nst < 2; k++) begin
         #5;
         if (mem_req_valid && mem_req_we) begin
            chk("loads_before_store", since, 4);
            since = 0;
            nst++;
         end
         if (ld_req_ready) begin
            exp_lm.push_back(ld_a);
            e.id = ld_i;
            e.data = ld_a ^ RD_KEY;
            exp_ld.push_back(e);
            since++;
            acc = 1'b1;
         end
         @(negedge clk);
         if (acc) begin
            ld_a = ld_a + 32'd4;
            ld_i = ld_i + 3'd1;
            ld_req_addr = ld_a;
            ld_req_id   = ld_i;
            acc = 1'b0;
         end
      end
      ld_req_valid = 1'b0;
      chk("starve_store_grants", nst, 2);
      wait_drain("drain_starve");

      // address hazard: load to 0x202 waits for buffered store to 0x200
      auto_ready = 1'b0;
      @(negedge clk);
      issue_load(32'h500, 3'd3, 1'b1);
      push_store(32'h200, 32'h1234_5678, 1'b1);
      @(negedge clk);
      commit_store_valid = 1'b0;
      ld_req_valid = 1'b1;
      ld_req_addr  = 32'h202;
      ld_req_id    = 3'd4;
      auto_ready   = 1'b1;
      st_seen = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk); #5;
         if (mem_req_valid && mem_req_we) st_seen = 1'b1;
         if (ld_req_ready) begin
            got = 1'b1;
            chk("hit_store_first", st_seen, 1);
            exp_lm.push_back(32'h202);
            e.id = 3'd4;
            e.data = 32'h202 ^ RD_KEY;
            exp_ld.push_back(e);
         end
      end
      chk("hit_load_accepted", got, 1);
      @(negedge clk);
      ld_req_valid = 1'b0;
      repeat (3) @(negedge clk);

      // flush while load id 2 waits; stores still drain
      resp_lat = 4;
      @(negedge clk);
      issue_load(32'h600, 3'd2, 1'b0);
      @(negedge clk);
      flush = 1'b1;
      push_store(32'h3000, 32'h3333_0000, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      push_store(32'h3004, 32'h3333_0001, 1'b1);
      @(negedge clk);
      commit_store_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         #5;
         if (mem_resp_valid && !mem_req_we) begin
            found = 1'b1;
            chk("flush_resp_suppressed", ld_resp_valid, 0);
         end
         if (!found) @(negedge clk);
      end
      chk("flush_resp_seen", found, 1);
      wait_drain("drain_after_flush");
      resp_lat = 1;

      // reset during the request phase of a store
      auto_ready = 1'b0;
      @(negedge clk);
      push_store(32'h7000, 32'h7777_7777, 1'b0);
      @(negedge clk);
      commit_store_valid = 1'b0;
      n = 0;
      #5;
      while (!mem_req_valid && n < 10) begin
         @(negedge clk); #5;
         n++;
      end
      chk("st_req_before_reset", mem_req_valid, 1);
      rst_n = 1'b0;
      ld_req_valid = 1'b1;
      ld_req_addr  = 32'hA00;
      ld_req_id    = 3'd1;
      @(negedge clk);
      #5;
      chk("rstmid_mem_req_valid", mem_req_valid, 0);
      chk("rstmid_sb_empty", sb_empty, 1);
      chk("rstmid_sb_full", sb_full, 0);
      chk("rstmid_ld_req_ready", ld_req_ready, 0);
      chk("rstmid_ld_resp_valid", ld_resp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ld_req_valid = 1'b0;
      auto_ready = 1'b1;
      #5 chk("post_rst_mem_req_valid", mem_req_valid, 0);

      // reset during load wait; the late response lands in IDLE
      resp_lat = 3;
      @(negedge clk);
      issue_load(32'hB00, 3'd6, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #5 chk("late_resp_ignored", ld_resp_valid, 0);
      resp_lat = 1;
      @(negedge clk);
      issue_load(32'h900, 3'd7, 1'b1);
      repeat (4) @(negedge clk);

      chk("left_st", exp_st.size(), 0);
      chk("left_ldmem", exp_lm.size(), 0);
      chk("left_ldresp", exp_ld.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
